// File: rtl/alu_pkg.sv
// alu_pkg: shared select codes, opcodes and the issued-operation record for the ALU issue stage
package alu_pkg;
  localparam logic [3:0] SEL_ADD    = 4'b0000;
  localparam logic [3:0] SEL_SUB    = 4'b1000;
  localparam logic [3:0] SEL_SLL    = 4'b0001;
  localparam logic [3:0] SEL_SLT    = 4'b0010;
  localparam logic [3:0] SEL_SLTU   = 4'b0011;
  localparam logic [3:0] SEL_XOR    = 4'b0100;
  localparam logic [3:0] SEL_SRL    = 4'b0101;
  localparam logic [3:0] SEL_SRA    = 4'b1101;
  localparam logic [3:0] SEL_OR     = 4'b0110;
  localparam logic [3:0] SEL_AND    = 4'b0111;
  localparam logic [3:0] SEL_PASS_Y = 4'b1111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  select;
    logic [4:0]  rd;
    logic        wb;
    logic        illegal;
  } alu_issue_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I decode into ALU select code and X/Y operands
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output alu_issue_t  issue_o
);
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_u, x, y;
  logic [3:0]  sel;
  logic        shift, ok, wb;
  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign rd    = instr_i[11:7];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  always_comb begin
    ok  = 1'b1;
    wb  = 1'b1;
    x   = rs1_i;
    y   = imm_i;
    sel = SEL_ADD;
    case (opc)
      OPC_OP: begin
        ok  = f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        sel = {f7[5], f3};
        y   = shift ? {27'b0, rs2_i[4:0]} : rs2_i;
      end
      OPC_OPIMM: begin
        ok  = !shift || f7 == 7'b0 || (f7 == F7_ALT && f3 == 3'b101);
        sel = (f3 == 3'b101 && f7 == F7_ALT) ? SEL_SRA : {1'b0, f3};
        y   = shift ? {27'b0, instr_i[24:20]} : imm_i;
      end
      OPC_LUI: begin
        x   = '0;
        y   = imm_u;
        sel = SEL_PASS_Y;
      end
      OPC_AUIPC: begin
        x = pc_i;
        y = imm_u;
      end
      OPC_LOAD:  wb = 1'b0;
      OPC_STORE: begin
        y  = imm_s;
        wb = 1'b0;
      end
      OPC_BRANCH: begin
        ok  = f3[2:1] != 2'b01;
        sel = f3[2] ? (f3[1] ? SEL_SLTU : SEL_SLT) : SEL_SUB;
        y   = rs2_i;
        wb  = 1'b0;
      end
      default: ok = 1'b0;
    endcase
  end
  // Illegal words still travel down the pipe, but as a harmless zero ADD
  assign issue_o.x       = ok ? x : '0;
  assign issue_o.y       = ok ? y : '0;
  assign issue_o.select  = ok ? sel : SEL_ADD;
  assign issue_o.rd      = rd;
  assign issue_o.wb      = ok && wb && rd != 5'd0;
  assign issue_o.illegal = !ok;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered ALU issue stage with a 2-entry skid buffer and flopped in_ready
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_x,
  output logic [XLEN-1:0] out_y,
  output logic [3:0]      out_select,
  output logic [4:0]      out_rd,
  output logic            out_wb,
  output logic            out_illegal
);
  alu_issue_t dec, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, acc, xfer;
  alu_decode u_decode (
    .instr_i(in_instr),
    .pc_i   (in_pc),
    .rs1_i  (in_rs1),
    .rs2_i  (in_rs2),
    .issue_o(dec)
  );
  assign acc  = in_valid && rdy_q;
  assign xfer = main_v_q && out_ready;
  // A full skid implies in_ready is low, so no accept can coincide with it
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      if (xfer) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (!main_v_q || xfer) begin
      main_v_d = acc;
      main_d   = acc ? dec : main_q;
    end else if (acc) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
    end
  end
  assign in_ready    = rdy_q;
  assign out_valid   = main_v_q;
  assign out_x       = main_q.x;
  assign out_y       = main_q.y;
  assign out_select  = main_q.select;
  assign out_rd      = main_q.rd;
  assign out_wb      = main_q.wb;
  assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors checked against a queue-based reference model of the issue stage
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] out_x, out_y;
  logic [3:0]  out_select;
  logic [4:0]  out_rd;
  logic        out_wb, out_illegal;
  int tests = 0, fails = 0;
  bit armed = 1'b0;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;
  exp_t q[$];
  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_select(out_select), .out_rd(out_rd), .out_wb(out_wb), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit ok;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] ii;
    opc = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    ii = {{20{w[31]}}, w[31:20]};
    e = '0;
    e.rd = w[11:7];
    ok = 1'b1;
    if (opc == 7'h33) begin
      ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      e.sel = {f7[5], f3};
      e.x = a;
      e.y = (f3 == 1 || f3 == 5) ? (b & 32'h1f) : b;
      e.wb = 1'b1;
    end else if (opc == 7'h13) begin
      if (f3 == 1) ok = f7 == 0;
      if (f3 == 5) ok = f7 == 0 || f7 == 7'h20;
      e.sel = (f3 == 5 && f7 == 7'h20) ? 4'hd : {1'b0, f3};
      e.x = a;
      e.y = (f3 == 1 || f3 == 5) ? {27'b0, w[24:20]} : ii;
      e.wb = 1'b1;
    end else if (opc == 7'h37) begin
      e.sel = 4'hf;
      e.y = w & 32'hfffff000;
      e.wb = 1'b1;
    end else if (opc == 7'h17) begin
      e.x = pc;
      e.y = w & 32'hfffff000;
      e.wb = 1'b1;
    end else if (opc == 7'h03) begin
      e.x = a;
      e.y = ii;
    end else if (opc == 7'h23) begin
      e.x = a;
      e.y = {{20{w[31]}}, w[31:25], w[11:7]};
    end else if (opc == 7'h63) begin
      ok = !(f3 == 2 || f3 == 3);
      e.sel = (f3 < 2) ? 4'h8 : (f3 < 6) ? 4'h2 : 4'h3;
      e.x = a;
      e.y = b;
    end else ok = 1'b0;
    if (!ok) begin
      e.x = 0; e.y = 0; e.sel = 0; e.wb = 0; e.ill = 1;
    end
    if (e.rd == 0) e.wb = 0;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    int n;
    n = q.size();
    if (rst) begin
      q.delete();
      armed <= 1'b1;
    end else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back(model(in_instr, in_pc, in_rs1, in_rs2));
    end
  end
  always @(negedge clk) if (armed) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    if (q.size() > 0) begin
      chk("x", out_x, q[0].x);
      chk("y", out_y, q[0].y);
      chk("select", {28'b0, out_select}, {28'b0, q[0].sel});
      chk("rd", {27'b0, out_rd}, {27'b0, q[0].rd});
      chk("wb", {31'b0, out_wb}, {31'b0, q[0].wb});
      chk("illegal", {31'b0, out_illegal}, {31'b0, q[0].ill});
    end
  end
  task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    in_instr = w; in_pc = pc; in_rs1 = a; in_rs2 = b; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) begin
      fails++;
      $display("FAIL send_timeout actual=stalled required=accept instr=%h", w);
    end
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_x"}, out_x, 32'd0);
    chk({tag, "_y"}, out_y, 32'd0);
    chk({tag, "_sel"}, {28'b0, out_select}, 32'd0);
    chk({tag, "_rd"}, {27'b0, out_rd}, 32'd0);
    chk({tag, "_wb_ill"}, {30'b0, out_wb, out_illegal}, 32'd0);
  endtask
  logic [31:0] mix [12] = '{32'h002081B3, 32'h40208233, 32'h002091B3, 32'h4020D1B3,
                           32'hFFB0A193, 32'h0020A623, 32'hFFC0A383, 32'h0000007F,
                           32'h00208033, 32'h022081B3, 32'h0030D093, 32'h0020F463};
  initial begin
    exp_t m;
    m = model(32'h4030D093, 0, 32'h80000000, 0);
    chk("model_srai_y", m.y, 32'd3);
    m = model(32'h0020A623, 0, 32'd100, 0);
    chk("model_sw_y", m.y, 32'd12);
    idle(2);
    chk_reset_vals("rst0");
    rst = 1'b0;
    send(32'h002081B3, 0, 5, 7);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_x", out_x, 5);
    chk("add_y", out_y, 7);
    chk("add_sel_rd_wb", {out_select, out_rd, out_wb}, {4'h0, 5'd3, 1'b1});
    send(32'h4030D093, 0, 32'h80000000, 0);
    chk("srai_sel", {28'b0, out_select}, 32'hd);
    chk("srai_y", out_y, 3);
    chk("srai_ill", {31'b0, out_illegal}, 0);
    send(32'h0230D093, 0, 32'h80000000, 0);
    chk("srai_bad_ill_wb", {30'b0, out_illegal, out_wb}, 32'd2);
    chk("srai_bad_xy", out_x | out_y, 0);
    send(32'h123452B7, 0, 0, 0);
    chk("lui_sel", {28'b0, out_select}, 32'hf);
    chk("lui_y", out_y, 32'h12345000);
    send(32'h00001317, 32'h100, 0, 0);
    chk("auipc_sel", {28'b0, out_select}, 0);
    chk("auipc_x", out_x, 32'h100);
    chk("auipc_y", out_y, 32'h1000);
    send(32'h0020C463, 0, 32'hFFFFFFFF, 1);
    chk("blt_sel", {28'b0, out_select}, 32'h2);
    chk("blt_wb", {31'b0, out_wb}, 0);
    send(32'h0020A463, 0, 1, 2);
    chk("br010_ill", {31'b0, out_illegal}, 1);
    idle(2);
    out_ready = 1'b0;
    send(32'h002081B3, 0, 11, 1);
    send(32'h40208233, 0, 20, 3);
    in_instr = 32'hFFF00293; in_rs1 = 0; in_rs2 = 0; in_valid = 1'b1;
    idle(3);
    chk("bp_in_ready", {31'b0, in_ready}, 0);
    chk("bp_hold_x", out_x, 11);
    out_ready = 1'b1;
    idle(1);
    chk("bp_second_x", out_x, 20);
    chk("bp_second_sel", {28'b0, out_select}, 32'h8);
    chk("bp_ready_back", {31'b0, in_ready}, 1);
    idle(1);
    in_valid = 1'b0;
    chk("bp_third_y", out_y, 32'hFFFFFFFF);
    idle(2);
    out_ready = 1'b0;
    send(32'h002081B3, 0, 1, 2);
    send(32'h123452B7, 0, 0, 0);
    rst = 1'b1;
    idle(1);
    chk_reset_vals("rst_mid");
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_instr = mix[$urandom_range(0, 11)];
      in_pc = $urandom; in_rs1 = $urandom; in_rs2 = $urandom;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      idle(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue stage that drives the 32-bit ALU. It decodes an RV32I instruction word into the ALU's 4-bit `select` code, forms the X/Y operands (register, immediate, PC), and presents them with a valid/ready handshake. A 2-entry skid buffer keeps `in_ready` fully registered. It sits between register-file read and the ALU/writeback stage.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports (clock and reset are listed first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the upstream instruction is valid.
- `in_ready`  out  1  the stage can accept an instruction; driven directly from a flop.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of the instruction.
- `in_rs1`, `in_rs2`  in  32 each  register-file read data.
- `out_valid`  out  1  the ALU operands are valid.
- `out_ready`  in  1  downstream accepts the operands.
- `out_x`, `out_y`  out  32 each  ALU operands X and Y.
- `out_select`  out  4  ALU operation code.
- `out_rd`  out  5  destination register, `in_instr[11:7]`.
- `out_wb`  out  1  write-back enable.
- `out_illegal`  out  1  the instruction is not decodable by this stage.

## Operation
Select codes: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111, PASS_Y=1111.

Decode is keyed on opcode `instr[6:0]`:
- **OP (0110011):**
  - select = {f7[5], f3}.
  - f7 must be 0000000, or 0100000 with f3 ∈ {000, 101}; anything else is illegal.
  - X=rs1, Y=rs2. For shift ops, Y = {27'b0, rs2[4:0]}.
  - wb=1.
- **OP-IMM (0010011):**
  - Immediate is I-type, sign-extended.
  - select = {0, f3}, except f3=101 with f7=0100000, which gives SRA.
  - Shifts: Y = {27'b0, shamt}. f7 must be 0000000, or 0100000 for SRAI only; otherwise illegal.
  - X=rs1, wb=1.
- **LUI (0110111):** select=PASS_Y, Y = {instr[31:12], 12'b0}, X=0, wb=1.
- **AUIPC (0010111):** select=ADD, X=pc, Y=U-imm, wb=1.
- **LOAD (0000011) / STORE (0100011):** select=ADD, X=rs1, Y = I-imm or S-imm. wb=0 (the address is computed here; memory owns writeback).
- **BRANCH (1100011):**
  - f3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → illegal.
  - X=rs1, Y=rs2, wb=0.
- **Any other opcode:** illegal.

Illegal instructions still flow through the stage: illegal=1, select=ADD, X=Y=0, wb=0.

If rd=0, wb is forced to 0.

All immediates are sign-extended to 32 bits. No arithmetic is performed in this block.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented at `out_*` after edge N.
- An accept occurs when `in_valid & in_ready`. A transfer out occurs when `out_valid & out_ready`.
- Skid buffer has 2 entries:
  - Main register drives `out_*`; a skid register holds one overflow entry.
  - `in_ready` is registered and equals "skid empty".
  - If an accept happens while main is full and not draining, the decoded entry goes to skid and `in_ready` drops on the next cycle.
  - When main drains and skid is full, skid moves to main and `in_ready` rises the next cycle.
- Simultaneous accept and transfer with skid empty: main is replaced, `out_valid` stays 1, and nothing is lost or duplicated.
- While `out_valid=1 & out_ready=0`, all `out_*` hold stable.
- Reset: `out_valid`=0, `in_ready`=1, `out_x`=`out_y`=0, `out_select`=0000, `out_rd`=0, `out_wb`=0, `out_illegal`=0, skid empty.
  - Reset asserted mid-stream discards both entries. No transfer occurs in the reset cycle.
- Order is strictly FIFO, with at most 2 entries in flight.

## Structure
- Shared package `alu_pkg` holds:
  - select code constants (ADD…PASS_Y);
  - opcode constants;
  - a packed struct `alu_issue_t` {x, y, select, rd, wb, illegal}.
- Sub-module `alu_decode`: purely combinational, mapping (instr, pc, rs1, rs2) → `alu_issue_t`.
- The top level holds only the main and skid registers and the handshake flops.

## Test plan
- **ADD:** `ADD x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 → the next cycle gives out_valid=1, select=0000, X=5, Y=7, rd=3, wb=1.
- **SRAI:** 0x4030D093 (`SRAI x1,x1,3`), rs1=0x80000000 → select=1101, Y=3, illegal=0. The same word with f7=0x01 → illegal=1, wb=0, X=Y=0.
- **LUI and AUIPC:** `LUI x5,0x12345` → select=1111, Y=0x12345000. `AUIPC` with pc=0x100, imm=1 → select=0000, X=0x100, Y=0x1000.
- **BLT:** BLT with rs1=−1, rs2=1 → select=0010, wb=0. BRANCH with f3=010 → illegal=1.
- **Backpressure:** hold out_ready=0 and offer 3 back-to-back instructions.
  - Expected: 2 accepted, `in_ready`=0 from the cycle after the 2nd accept, outputs stable.
  - Release out_ready: both entries are delivered in order, then the 3rd is accepted.
- **Reset mid-stream:** assert `rst` for 1 cycle with 2 entries held → the next cycle shows out_valid=0, in_ready=1, all outputs at their reset values.
